// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave responder.
package spi_pkg;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_slv_state_e;

  localparam int   SPI_BYTE_W    = 8;
  localparam logic SPI_IDLE_MISO = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses; edges are suppressed until the
// chain holds real samples so a pad level present at reset release is not seen as an edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES:0]   vld_r;
  logic                   prev_r;
  logic                   rise_r;
  logic                   fall_r;

  // Synchronizer chain, previous-sample register and edge pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
      vld_r  <= '0;
      prev_r <= RESET_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      vld_r  <= {vld_r[SYNC_STAGES-1:0], 1'b1};
      prev_r <= sync_r[SYNC_STAGES-1];
      rise_r <= vld_r[SYNC_STAGES] & sync_r[SYNC_STAGES-1] & ~prev_r;
      fall_r <= vld_r[SYNC_STAGES] & ~sync_r[SYNC_STAGES-1] & prev_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave core: oversampled SCLK/MOSI/n_SS, byte and word receive, one-entry TX buffer.
// Build option SPI_SLAVE_FRAME_ERR_EN enables the frame_err pulse on an aborted partial byte.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_BYTE_W,
  parameter int WORD_BYTES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         SCLK,
  input  logic                         MOSI,
  input  logic                         n_SS,
  output logic                         MISO,
  input  logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [DATA_W-1:0]            rx_byte,
  output logic                         rx_byte_valid,
  output logic [DATA_W*WORD_BYTES-1:0] rx_word,
  output logic                         rx_word_valid,
  output logic                         busy,
  output logic                         frame_err
);

  localparam int WW  = DATA_W * WORD_BYTES;
  localparam int BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  spi_slv_state_e         state_r, state_s;
  logic [BW-1:0]          bit_cnt_r, bit_cnt_s;
  logic [BCW-1:0]         byte_cnt_r, byte_cnt_s;
  logic [DATA_W-1:0]      rx_shift_r, rx_shift_s, rx_next_s;
  logic [DATA_W-1:0]      tx_shift_r, tx_shift_s, load_val_s;
  logic [WW-1:0]          word_acc_r, word_acc_s, acc_next_s;
  logic                   byte_done_r, byte_done_s;
  logic [DATA_W-1:0]      tx_buf_r, tx_buf_s;
  logic                   tx_full_r, tx_full_s, write_s, load_s;
  logic [DATA_W-1:0]      rx_byte_r, rx_byte_s;
  logic [WW-1:0]          rx_word_r, rx_word_s;
  logic                   rx_byte_valid_r, rx_byte_valid_s;
  logic                   rx_word_valid_r, rx_word_valid_s;
  logic                   frame_err_r, frame_err_s;
  logic                   miso_r, busy_r, tx_ready_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   mosi_s;
  logic                   sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(SCLK), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset(reset), .din(n_SS), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  // MOSI only needs its level, sampled on synchronized SCLK rising edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_sync_r <= '0;
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign rx_next_s  = {rx_shift_r[DATA_W-2:0], mosi_s};
  assign acc_next_s = (word_acc_r << DATA_W) | WW'(rx_next_s);
  assign load_val_s = tx_full_r ? tx_buf_r : '0;

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    state_s         = state_r;
    bit_cnt_s       = bit_cnt_r;
    byte_cnt_s      = byte_cnt_r;
    rx_shift_s      = rx_shift_r;
    tx_shift_s      = tx_shift_r;
    word_acc_s      = word_acc_r;
    byte_done_s     = byte_done_r;
    rx_byte_s       = rx_byte_r;
    rx_word_s       = rx_word_r;
    rx_byte_valid_s = 1'b0;
    rx_word_valid_s = 1'b0;
    frame_err_s     = 1'b0;
    load_s          = 1'b0;
    case (state_r)
      SPI_IDLE: begin
        if (ss_fall_s) begin
          state_s     = SPI_ACTIVE;
          load_s      = 1'b1;
          tx_shift_s  = load_val_s;
          bit_cnt_s   = '0;
          byte_cnt_s  = '0;
          byte_done_s = 1'b0;
        end else begin
          state_s = SPI_IDLE;
        end
      end
      SPI_ACTIVE: begin
        if (ss_rise_s) begin
          // Partial byte and partial word are dropped without any valid pulse.
          state_s     = SPI_IDLE;
          bit_cnt_s   = '0;
          byte_cnt_s  = '0;
          byte_done_s = 1'b0;
          rx_shift_s  = '0;
          word_acc_s  = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_s = (bit_cnt_r != '0);
`endif
        end else if (sclk_rise_s) begin
          rx_shift_s = rx_next_s;
          if (bit_cnt_r == BW'(DATA_W - 1)) begin
            bit_cnt_s       = '0;
            rx_byte_s       = rx_next_s;
            rx_byte_valid_s = 1'b1;
            byte_done_s     = 1'b1;
            if (byte_cnt_r == BCW'(WORD_BYTES - 1)) begin
              byte_cnt_s      = '0;
              rx_word_s       = acc_next_s;
              rx_word_valid_s = 1'b1;
              word_acc_s      = '0;
            end else begin
              byte_cnt_s = byte_cnt_r + BCW'(1'b1);
              word_acc_s = acc_next_s;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + BW'(1'b1);
          end
        end else if (sclk_fall_s) begin
          if (bit_cnt_r != '0) begin
            tx_shift_s = {tx_shift_r[DATA_W-2:0], 1'b0};
          end else if (byte_done_r) begin
            load_s     = 1'b1;
            tx_shift_s = load_val_s;
          end else begin
            load_s = 1'b0;
          end
        end else begin
          state_s = SPI_ACTIVE;
        end
      end
      default: begin
        state_s = SPI_IDLE;
      end
    endcase
  end

  assign write_s   = tx_valid & ~tx_full_r;
  assign tx_full_s = write_s | (tx_full_r & ~load_s);
  assign tx_buf_s  = write_s ? tx_data : tx_buf_r;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= SPI_IDLE;
      bit_cnt_r       <= '0;
      byte_cnt_r      <= '0;
      rx_shift_r      <= '0;
      tx_shift_r      <= '0;
      word_acc_r      <= '0;
      byte_done_r     <= 1'b0;
      tx_buf_r        <= '0;
      tx_full_r       <= 1'b0;
      rx_byte_r       <= '0;
      rx_word_r       <= '0;
      rx_byte_valid_r <= 1'b0;
      rx_word_valid_r <= 1'b0;
      frame_err_r     <= 1'b0;
      miso_r          <= SPI_IDLE_MISO;
      busy_r          <= 1'b0;
      tx_ready_r      <= 1'b1;
    end else begin
      state_r         <= state_s;
      bit_cnt_r       <= bit_cnt_s;
      byte_cnt_r      <= byte_cnt_s;
      rx_shift_r      <= rx_shift_s;
      tx_shift_r      <= tx_shift_s;
      word_acc_r      <= word_acc_s;
      byte_done_r     <= byte_done_s;
      tx_buf_r        <= tx_buf_s;
      tx_full_r       <= tx_full_s;
      rx_byte_r       <= rx_byte_s;
      rx_word_r       <= rx_word_s;
      rx_byte_valid_r <= rx_byte_valid_s;
      rx_word_valid_r <= rx_word_valid_s;
      frame_err_r     <= frame_err_s;
      miso_r          <= (state_s == SPI_ACTIVE) ? tx_shift_s[DATA_W-1] : SPI_IDLE_MISO;
      busy_r          <= (state_s == SPI_ACTIVE);
      tx_ready_r      <= ~tx_full_s;
    end
  end

  assign MISO          = miso_r;
  assign busy          = busy_r;
  assign tx_ready      = tx_ready_r;
  assign rx_byte       = rx_byte_r;
  assign rx_word       = rx_word_r;
  assign rx_byte_valid = rx_byte_valid_r;
  assign rx_word_valid = rx_word_valid_r;
  assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: table of SPI frames plus hand-written corner sequences.
module tb_spi_slave_responder;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam int EXP_FERR = 1;
`else
  localparam int EXP_FERR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, SCLK, MOSI, n_SS, tx_valid;
  logic [7:0]  tx_data;
  logic        MISO, tx_ready, rx_byte_valid, rx_word_valid, busy, frame_err;
  logic [7:0]  rx_byte;
  logic [15:0] rx_word;

  int nvec = 0;
  int nerr = 0;
  int n_bv = 0, n_wv = 0, n_ferr = 0, n_nocoin = 0, n_rdyf = 0;
  logic rdy_q = 1'b1;

  typedef struct {
    logic [7:0]  b0, b1;
    int          nbytes;
    logic        pre_wr;
    logic [7:0]  pre_data;
    logic        mid_wr;
    logic [7:0]  mid_data;
    logic [7:0]  exp_byte;
    logic [15:0] exp_word;
    int          exp_bp, exp_wp, exp_rdyf;
    logic [7:0]  exp_m0, exp_m1;
  } vec_t;

  vec_t vecs[4];

  spi_slave_responder dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .n_SS(n_SS), .MISO(MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rx_word(rx_word), .rx_word_valid(rx_word_valid),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse and handshake-transition counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_byte_valid) n_bv <= n_bv + 1;
    if (rx_word_valid) n_wv <= n_wv + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if (rx_word_valid && !rx_byte_valid) n_nocoin <= n_nocoin + 1;
    if (rdy_q && !tx_ready) n_rdyf <= n_rdyf + 1;
    rdy_q <= tx_ready;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!tx_ready && n < 20) begin
      tick(1);
      n++;
    end
    chk("tx_ready_wait", tx_ready, 1'b1);
  endtask

  // Mode 0 master: MOSI changes while SCLK is low, MISO is sampled just before SCLK rises.
  task automatic xfer(input logic [7:0] d, input int nbits, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = d[7-i];
      tick(5);
      miso_b = {miso_b[6:0], MISO};
      SCLK = 1'b1;
      tick(5);
      SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input vec_t v, output logic [7:0] m0, output logic [7:0] m1);
    m0 = 8'h00;
    m1 = 8'h00;
    if (v.pre_wr) begin
      write_tx(v.pre_data);
      chk("pre_wr_ready_drop", tx_ready, 1'b0);
    end
    n_SS = 1'b0;
    tick(6);
    chk("busy_in_frame", busy, 1'b1);
    if (v.mid_wr) begin
      wait_ready();
      write_tx(v.mid_data);
    end
    xfer(v.b0, 8, m0);
    if (v.nbytes > 1) xfer(v.b1, 8, m1);
    tick(6);
    n_SS = 1'b1;
    tick(6);
    chk("busy_after_frame", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] m0, m1, dummy;
    int bv0, wv0, fe0, nc0, rf0;

    vecs[0] = '{b0:8'hA5, b1:8'h00, nbytes:1, pre_wr:1'b0, pre_data:8'h00, mid_wr:1'b0, mid_data:8'h00,
                exp_byte:8'hA5, exp_word:16'h0000, exp_bp:1, exp_wp:0, exp_rdyf:0, exp_m0:8'h00, exp_m1:8'h00};
    vecs[1] = '{b0:8'h12, b1:8'h34, nbytes:2, pre_wr:1'b0, pre_data:8'h00, mid_wr:1'b0, mid_data:8'h00,
                exp_byte:8'h34, exp_word:16'h1234, exp_bp:2, exp_wp:1, exp_rdyf:0, exp_m0:8'h00, exp_m1:8'h00};
    vecs[2] = '{b0:8'h0F, b1:8'hF0, nbytes:2, pre_wr:1'b1, pre_data:8'h3C, mid_wr:1'b1, mid_data:8'hC3,
                exp_byte:8'hF0, exp_word:16'h0FF0, exp_bp:2, exp_wp:1, exp_rdyf:2, exp_m0:8'h3C, exp_m1:8'hC3};
    vecs[3] = '{b0:8'hC6, b1:8'h00, nbytes:1, pre_wr:1'b1, pre_data:8'h7E, mid_wr:1'b0, mid_data:8'h00,
                exp_byte:8'hC6, exp_word:16'h0FF0, exp_bp:1, exp_wp:0, exp_rdyf:1, exp_m0:8'h7E, exp_m1:8'h00};

    reset = 1'b1; SCLK = 1'b0; MOSI = 1'b0; n_SS = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(5);
    chk("rst_miso", MISO, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_rx_word", rx_word, 16'h0000);
    chk("rst_valids", {rx_byte_valid, rx_word_valid, frame_err}, 3'b000);
    chk("rst_busy", busy, 1'b0);

    for (int i = 0; i < 4; i++) begin
      bv0 = n_bv; wv0 = n_wv; fe0 = n_ferr; nc0 = n_nocoin; rf0 = n_rdyf;
      run_frame(vecs[i], m0, m1);
      chk($sformatf("v%0d_rx_byte", i), rx_byte, vecs[i].exp_byte);
      chk($sformatf("v%0d_rx_word", i), rx_word, vecs[i].exp_word);
      chk($sformatf("v%0d_byte_pulses", i), n_bv - bv0, vecs[i].exp_bp);
      chk($sformatf("v%0d_word_pulses", i), n_wv - wv0, vecs[i].exp_wp);
      chk($sformatf("v%0d_word_not_coincident", i), n_nocoin - nc0, 0);
      chk($sformatf("v%0d_frame_err", i), n_ferr - fe0, 0);
      chk($sformatf("v%0d_ready_drops", i), n_rdyf - rf0, vecs[i].exp_rdyf);
      chk($sformatf("v%0d_tx_ready_end", i), tx_ready, 1'b1);
      chk($sformatf("v%0d_miso_b0", i), m0, vecs[i].exp_m0);
      if (vecs[i].nbytes > 1) chk($sformatf("v%0d_miso_b1", i), m1, vecs[i].exp_m1);
    end

    // Abort after 5 bits, then a clean frame carrying 0x5A.
    bv0 = n_bv; wv0 = n_wv; fe0 = n_ferr;
    n_SS = 1'b0;
    tick(6);
    xfer(8'hFF, 5, dummy);
    tick(6);
    n_SS = 1'b1;
    tick(6);
    chk("abort_byte_pulses", n_bv - bv0, 0);
    chk("abort_word_pulses", n_wv - wv0, 0);
    chk("abort_frame_err", n_ferr - fe0, EXP_FERR);
    chk("abort_rx_byte_kept", rx_byte, 8'hC6);
    chk("abort_busy", busy, 1'b0);
    bv0 = n_bv;
    vecs[0].b0 = 8'h5A;
    run_frame(vecs[0], m0, m1);
    chk("post_abort_rx_byte", rx_byte, 8'h5A);
    chk("post_abort_pulses", n_bv - bv0, 1);
    chk("post_abort_rx_word", rx_word, 16'h0FF0);

    // Reset mid-byte with n_SS held low: outputs clear at once and the frame does not resume.
    write_tx(8'hFF);
    n_SS = 1'b0;
    tick(6);
    write_tx(8'h55);
    xfer(8'h00, 3, dummy);
    tick(5);
    chk("pre_reset_miso", MISO, 1'b1);
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #2;
    chk("mid_rst_miso", MISO, 1'b0);
    chk("mid_rst_tx_ready", tx_ready, 1'b1);
    chk("mid_rst_rx_byte", rx_byte, 8'h00);
    chk("mid_rst_rx_word", rx_word, 16'h0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valids", {rx_byte_valid, rx_word_valid, frame_err}, 3'b000);
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("no_resume_busy", busy, 1'b0);
    chk("no_resume_miso", MISO, 1'b0);
    n_SS = 1'b1;
    tick(6);
    vecs[0].b0 = 8'h81;
    run_frame(vecs[0], m0, m1);
    chk("post_reset_rx_byte", rx_byte, 8'h81);
    chk("post_reset_miso", m0, 8'h00);

    // Write lands in the same cycle as the n_SS load with the buffer empty.
    n_SS = 1'b0;
    tick(3);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    chk("race_write_captured", tx_ready, 1'b0);
    tick(2);
    xfer(8'h11, 8, m0);
    xfer(8'h22, 8, m1);
    tick(6);
    n_SS = 1'b1;
    tick(6);
    chk("race_underrun_byte", m0, 8'h00);
    chk("race_next_byte", m1, 8'h96);
    chk("race_rx_word", rx_word, 16'h1122);
    chk("race_tx_ready_end", tx_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
